// File: rtl/jpeg_pkg.sv
// Shared constants, scheduler state encoding and the JPEG zigzag scan table
// for the MCU/DCT datapath.
package jpeg_pkg;

    localparam int NUM_MCUS    = 28;
    localparam int NUM_STRIPS  = 28;
    localparam int MCU_COEFS   = 64;
    localparam int DCT_LATENCY = 2;
    localparam int COEF_W      = 32;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_STRIP,
        SETTLE,
        STREAM,
        DONE
    } sched_state_t;

    // Scan ordinal -> raster coefficient index (row*8+col)
    localparam logic [5:0] ZIGZAG [MCU_COEFS] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/mcu_dct_scheduler_if.sv
// Coefficient stream from the scheduler to the packer/DMA: valid/ready
// handshake with MCU framing flags.
interface mcu_dct_scheduler_if #(
    parameter int COEF_W = 32
) ();

    logic              out_valid;
    logic              out_ready;
    logic [COEF_W-1:0] out_data;
    logic              out_sop;
    logic              out_eop;
    logic              out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_sop,
        output out_eop,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_sop,
        input  out_eop,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/zigzag_rom.sv
// Combinational scan-ordinal to coefficient-index map. Only built when
// SCHED_ZIGZAG_EN is defined; the raster build has no ROM at all.
`ifdef SCHED_ZIGZAG_EN
module zigzag_rom
    import jpeg_pkg::*;
(
    input  logic [5:0] ordinal_i,
    output logic [5:0] coef_idx_o
);

    assign coef_idx_o = ZIGZAG[ordinal_i];

endmodule
`endif

// File: rtl/mcu_dct_scheduler.sv
// Drains each captured strip MCU by MCU through the DCT and streams the 64
// coefficients per MCU. SCHED_ZIGZAG_EN selects zigzag instead of raster order.
module mcu_dct_scheduler
    import jpeg_pkg::*;
#(
    parameter int NUM_MCUS    = jpeg_pkg::NUM_MCUS,
    parameter int NUM_STRIPS  = jpeg_pkg::NUM_STRIPS,
    parameter int DCT_LATENCY = jpeg_pkg::DCT_LATENCY,
    parameter int COEF_W      = jpeg_pkg::COEF_W
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  strip_done,
    output logic [7:0]            strip_number,
    output logic [7:0]            mcu_sel,
    output logic [5:0]            coef_idx,
    input  logic [COEF_W-1:0]     dct_coef,
    mcu_dct_scheduler_if.master   out_if,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun
);

    localparam int              SETTLE_W   = $clog2(DCT_LATENCY + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(DCT_LATENCY);
    localparam logic [SETTLE_W-1:0] SETTLE_ONE  = SETTLE_W'(1);
    localparam logic [7:0]      MCU_LAST   = 8'(NUM_MCUS - 1);
    localparam logic [7:0]      STRIP_LAST = 8'(NUM_STRIPS - 1);
    localparam logic [5:0]      ORD_LAST   = 6'(MCU_COEFS - 1);

    sched_state_t        state_q, state_d;
    logic [7:0]          strip_q, strip_d;
    logic [7:0]          mcu_q, mcu_d;
    logic [5:0]          ord_q, ord_d;
    logic [SETTLE_W-1:0] settle_q, settle_d;
    logic                overrun_q, overrun_d;
    logic                beat;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            strip_q   <= 8'd0;
            mcu_q     <= 8'd0;
            ord_q     <= 6'd0;
            settle_q  <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            strip_q   <= strip_d;
            mcu_q     <= mcu_d;
            ord_q     <= ord_d;
            settle_q  <= settle_d;
            overrun_q <= overrun_d;
        end
    end

    assign beat = (state_q == STREAM) && out_if.out_ready;

    always_comb begin
        state_d   = state_q;
        strip_d   = strip_q;
        mcu_d     = mcu_q;
        ord_d     = ord_q;
        settle_d  = settle_q;
        overrun_d = overrun_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = WAIT_STRIP;
                    strip_d   = 8'd0;
                    mcu_d     = 8'd0;
                    ord_d     = 6'd0;
                    overrun_d = 1'b0;
                end
            end
            WAIT_STRIP: begin
                if (strip_done) begin
                    state_d  = SETTLE;
                    mcu_d    = 8'd0;
                    ord_d    = 6'd0;
                    settle_d = SETTLE_LOAD;
                end
            end
            SETTLE: begin
                if (settle_q <= SETTLE_ONE) begin
                    state_d = STREAM;
                end else begin
                    settle_d = settle_q - SETTLE_ONE;
                end
            end
            STREAM: begin
                if (beat) begin
                    if (ord_q != ORD_LAST) begin
                        ord_d = ord_q + 6'd1;
                    end else if (mcu_q != MCU_LAST) begin
                        state_d  = SETTLE;
                        mcu_d    = mcu_q + 8'd1;
                        ord_d    = 6'd0;
                        settle_d = SETTLE_LOAD;
                    end else begin
                        mcu_d = 8'd0;
                        ord_d = 6'd0;
                        if (strip_q != STRIP_LAST) begin
                            state_d = WAIT_STRIP;
                            strip_d = strip_q + 8'd1;
                        end else begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A new strip arriving mid-drain means capture clobbered the strip in flight
        if (strip_done && (state_q == SETTLE || state_q == STREAM)) begin
            overrun_d = 1'b1;
        end
    end

`ifdef SCHED_ZIGZAG_EN
    zigzag_rom u_zigzag_rom (
        .ordinal_i  (ord_q),
        .coef_idx_o (coef_idx)
    );
`else
    assign coef_idx = ord_q;
`endif

    assign strip_number     = strip_q;
    assign mcu_sel          = mcu_q;
    assign busy             = (state_q != IDLE);
    assign done             = (state_q == DONE);
    assign overrun          = overrun_q;

    // Framing follows the scan ordinal, not the raster index
    assign out_if.out_valid = (state_q == STREAM);
    assign out_if.out_data  = dct_coef;
    assign out_if.out_sop   = out_if.out_valid && (ord_q == 6'd0);
    assign out_if.out_eop   = out_if.out_valid && (ord_q == ORD_LAST);
    assign out_if.out_last  = out_if.out_eop && (mcu_q == MCU_LAST) && (strip_q == STRIP_LAST);

endmodule
